// File: rtl/spider_pkg.sv
// spider_pkg: shared types and constants for the spider hazard field
// (LFSR geometry, FSM state encoding, default playfield geometry).
package spider_pkg;

  // Pseudo-random source geometry. Right-shifting Galois form of
  // x^16 + x^14 + x^13 + x^11 + 1.
  localparam int              LFSR_W    = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Field controller states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SPAWN   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RESPAWN = 2'd3
  } field_state_t;

  // Default playfield geometry.
  localparam int DEF_STEP  = 32;
  localparam int DEF_X_MIN = 64;
  localparam int DEF_X_MAX = 896;
  localparam int DEF_Y_MIN = 64;
  localparam int DEF_Y_MAX = 832;
  localparam int DEF_PARK  = 700;

endpackage

// File: rtl/spider_lfsr.sv
// spider_lfsr: 16-bit Galois LFSR, loads the seed while reset is high and
// advances once per cycle otherwise. Shared with the food spawner.
module spider_lfsr
  import spider_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] lfsr
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  // Next state: shift right, fold the tap pattern in when a one falls out.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  // State register; seed must be nonzero or the sequence locks up.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/spider_field.sv
// spider_field: holds NUM_SPIDERS spider slots on a STEP-aligned grid, spawns
// them from an LFSR, detects snake/spider collisions, parks hit spiders and
// respawns them after RESPAWN_CYCLES.
// Optional build macro SPIDER_DRIFT_EN: every 2^20 cycles each alive spider
// steps one grid cell in an LFSR-chosen direction.
module spider_field
  import spider_pkg::*;
#(
  parameter int                NUM_SPIDERS    = 5,
  parameter int                COORD_W        = 12,
  parameter int                STEP           = DEF_STEP,
  parameter int                X_MIN          = DEF_X_MIN,
  parameter int                X_MAX          = DEF_X_MAX,
  parameter int                Y_MIN          = DEF_Y_MIN,
  parameter int                Y_MAX          = DEF_Y_MAX,
  parameter int                PARK           = DEF_PARK,
  parameter int                RESPAWN_CYCLES = 1024,
  parameter logic [LFSR_W-1:0] SEED           = 16'hACE1,
  localparam int               IDX_W          = (NUM_SPIDERS > 1) ? $clog2(NUM_SPIDERS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [COORD_W-1:0]             snake_x,
  input  logic [COORD_W-1:0]             snake_y,
  output logic [NUM_SPIDERS*COORD_W-1:0] spider_x_flat,
  output logic [NUM_SPIDERS*COORD_W-1:0] spider_y_flat,
  output logic [NUM_SPIDERS-1:0]         spider_alive,
  output logic                           hit_valid,
  output logic [IDX_W-1:0]               hit_idx,
  output logic [NUM_SPIDERS-1:0]         hit_mask,
  output logic                           ready
);

  localparam int                  TMR_W     = $clog2(RESPAWN_CYCLES + 1);
  localparam logic [COORD_W-1:0]  GRID_MASK = ~COORD_W'(STEP - 1);
  localparam logic [COORD_W-1:0]  PARK_C    = COORD_W'(PARK);
  localparam logic [COORD_W-1:0]  X_LO      = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0]  X_HI      = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0]  Y_LO      = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0]  Y_HI      = COORD_W'(Y_MAX);
  localparam logic [TMR_W-1:0]    TMR_LOAD  = TMR_W'(RESPAWN_CYCLES);

  field_state_t           state_q, state_d;
  logic [IDX_W-1:0]       slot_q, slot_d;          // spawn cursor, or slot being respawned
  logic [COORD_W-1:0]     x_q [NUM_SPIDERS];
  logic [COORD_W-1:0]     x_d [NUM_SPIDERS];
  logic [COORD_W-1:0]     y_q [NUM_SPIDERS];
  logic [COORD_W-1:0]     y_d [NUM_SPIDERS];
  logic [TMR_W-1:0]       tmr_q [NUM_SPIDERS];
  logic [TMR_W-1:0]       tmr_d [NUM_SPIDERS];
  logic [NUM_SPIDERS-1:0] alive_q, alive_d;
  logic                   hit_valid_q, hit_valid_d;
  logic [NUM_SPIDERS-1:0] hit_mask_q, hit_mask_d;
  logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;

  logic [LFSR_W-1:0]      lfsr;
  logic [COORD_W-1:0]     cand_x, cand_y;
  logic                   cand_ok;
  logic                   detect_en;
  logic [NUM_SPIDERS-1:0] snake_on, cand_on, due, hits;
  logic [IDX_W-1:0]       hit_lo, due_lo;

  spider_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED),
    .lfsr  (lfsr)
  );

  // Grid-snapped candidate; y comes from the byte-swapped LFSR so the two
  // axes are not trivially correlated.
  assign cand_x = COORD_W'(lfsr) & GRID_MASK;
  assign cand_y = COORD_W'({lfsr[7:0], lfsr[15:8]}) & GRID_MASK;

  // Per-slot comparators and output packing. Dead slots never match.
  for (genvar gi = 0; gi < NUM_SPIDERS; gi++) begin : g_slot
    assign snake_on[gi] = alive_q[gi] && (x_q[gi] == snake_x) && (y_q[gi] == snake_y);
    assign cand_on[gi]  = alive_q[gi] && (x_q[gi] == cand_x)  && (y_q[gi] == cand_y);
    assign due[gi]      = !alive_q[gi] && (tmr_q[gi] == '0);
    assign spider_x_flat[gi*COORD_W +: COORD_W] = x_q[gi];
    assign spider_y_flat[gi*COORD_W +: COORD_W] = y_q[gi];
  end

  assign cand_ok = (cand_x >= X_LO) && (cand_x <= X_HI) &&
                   (cand_y >= Y_LO) && (cand_y <= Y_HI) &&
                   !((cand_x == snake_x) && (cand_y == snake_y)) &&
                   !(|cand_on);

  assign detect_en = (state_q == ST_ACTIVE) || (state_q == ST_RESPAWN);
  assign hits      = detect_en ? snake_on : '0;

  // Priority encoders: lowest hit slot and lowest slot ready to respawn.
  always_comb begin
    hit_lo = '0;
    due_lo = '0;
    for (int i = NUM_SPIDERS - 1; i >= 0; i--) begin
      if (hits[i]) hit_lo = IDX_W'(i);
      if (due[i])  due_lo = IDX_W'(i);
    end
  end

`ifdef SPIDER_DRIFT_EN
  logic [19:0] drift_cnt_q, drift_cnt_d;
  logic        drift_tick;

  assign drift_cnt_d = drift_cnt_q + 1'b1;
  assign drift_tick  = &drift_cnt_q;

  // Free-running drift period counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      drift_cnt_q <= '0;
    end else begin
      drift_cnt_q <= drift_cnt_d;
    end
  end
`endif

  // Field next state: timers, drift, hits, spawn/respawn writes, FSM.
  always_comb begin
`ifdef SPIDER_DRIFT_EN
    int nx;
    int ny;
    nx = 0;
    ny = 0;
`endif
    state_d     = state_q;
    slot_d      = slot_q;
    x_d         = x_q;
    y_d         = y_q;
    tmr_d       = tmr_q;
    alive_d     = alive_q;
    hit_valid_d = |hits;
    hit_mask_d  = hits;
    hit_idx_d   = hit_lo;

    if (state_q != ST_IDLE) begin
      for (int i = 0; i < NUM_SPIDERS; i++) begin
        if (tmr_q[i] != '0) tmr_d[i] = tmr_q[i] - 1'b1;
      end
    end

`ifdef SPIDER_DRIFT_EN
    // Wander step; a hit below on the same slot overrides it.
    if (drift_tick && state_q != ST_IDLE) begin
      for (int i = 0; i < NUM_SPIDERS; i++) begin
        if (alive_q[i]) begin
          nx = int'(x_q[i]);
          ny = int'(y_q[i]);
          case (lfsr[(2*i) % LFSR_W +: 2])
            2'd0:    nx = nx + STEP;
            2'd1:    nx = nx - STEP;
            2'd2:    ny = ny + STEP;
            default: ny = ny - STEP;
          endcase
          if (nx >= X_MIN && nx <= X_MAX && ny >= Y_MIN && ny <= Y_MAX &&
              !(nx == int'(snake_x) && ny == int'(snake_y))) begin
            x_d[i] = COORD_W'(nx);
            y_d[i] = COORD_W'(ny);
          end
        end
      end
    end
`endif

    for (int i = 0; i < NUM_SPIDERS; i++) begin
      if (hits[i]) begin
        alive_d[i] = 1'b0;
        x_d[i]     = PARK_C;
        y_d[i]     = PARK_C;
        tmr_d[i]   = TMR_LOAD;
      end
    end

    // The slot written here is always dead, so it never collides with a hit.
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SPAWN;
          slot_d  = '0;
        end
      end
      ST_SPAWN: begin
        if (cand_ok) begin
          x_d[slot_q]     = cand_x;
          y_d[slot_q]     = cand_y;
          alive_d[slot_q] = 1'b1;
          if (slot_q == IDX_W'(NUM_SPIDERS - 1)) begin
            state_d = ST_ACTIVE;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (|due) begin
          state_d = ST_RESPAWN;
          slot_d  = due_lo;
        end
      end
      default: begin
        if (cand_ok) begin
          x_d[slot_q]     = cand_x;
          y_d[slot_q]     = cand_y;
          alive_d[slot_q] = 1'b1;
          state_d         = ST_ACTIVE;
        end
      end
    endcase
  end

  // Field state registers; reset parks everything and drops any pending hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      alive_q     <= '0;
      hit_valid_q <= 1'b0;
      hit_mask_q  <= '0;
      hit_idx_q   <= '0;
      for (int i = 0; i < NUM_SPIDERS; i++) begin
        x_q[i]   <= PARK_C;
        y_q[i]   <= PARK_C;
        tmr_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      alive_q     <= alive_d;
      hit_valid_q <= hit_valid_d;
      hit_mask_q  <= hit_mask_d;
      hit_idx_q   <= hit_idx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      tmr_q       <= tmr_d;
    end
  end

  assign spider_alive = alive_q;
  assign hit_valid    = hit_valid_q;
  assign hit_mask     = hit_mask_q;
  assign hit_idx      = hit_idx_q;
  assign ready        = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spider_field.sv
// tb_spider_field: randomized bench for spider_field with a cycle-level
// behavioural reference model; prints one line per hit event.
module tb_spider_field;

  localparam int          N     = 5;
  localparam int          CW    = 12;
  localparam int          STEP  = 32;
  localparam int          XMIN  = 64;
  localparam int          XMAX  = 896;
  localparam int          YMIN  = 64;
  localparam int          YMAX  = 832;
  localparam int          PARK  = 700;
  localparam int          RESP  = 16;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          IW    = 3;

  localparam int M_IDLE = 0, M_SPAWN = 1, M_ACTIVE = 2, M_RESPAWN = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [CW-1:0]   snake_x, snake_y;
  logic [N*CW-1:0] spider_x_flat, spider_y_flat;
  logic [N-1:0]    spider_alive, hit_mask;
  logic            hit_valid;
  logic [IW-1:0]   hit_idx;
  logic            ready;

  spider_field #(
    .NUM_SPIDERS(N), .COORD_W(CW), .STEP(STEP),
    .X_MIN(XMIN), .X_MAX(XMAX), .Y_MIN(YMIN), .Y_MAX(YMAX),
    .PARK(PARK), .RESPAWN_CYCLES(RESP), .SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .snake_x(snake_x), .snake_y(snake_y),
    .spider_x_flat(spider_x_flat), .spider_y_flat(spider_y_flat),
    .spider_alive(spider_alive), .hit_valid(hit_valid),
    .hit_idx(hit_idx), .hit_mask(hit_mask), .ready(ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int        m_phase, m_slot;
  int        m_x [N];
  int        m_y [N];
  int        m_tmr [N];
  bit        m_alive [N];
  bit [15:0] m_lfsr;
  bit        m_hv;
  int        m_hidx;
  bit [N-1:0] m_hmask;

  // Polynomial x^16+x^14+x^13+x^11+1 in right-shift Galois form.
  function automatic bit [15:0] lfsr_next(input bit [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk) begin : ref_model
    int cx, cy, l, due, hidx;
    bit ok;
    bit [N-1:0] hits;
    if (reset) begin
      m_phase = M_IDLE; m_slot = 0; m_lfsr = SEED;
      m_hv = 0; m_hidx = 0; m_hmask = '0;
      for (int i = 0; i < N; i++) begin
        m_x[i] = PARK; m_y[i] = PARK; m_alive[i] = 0; m_tmr[i] = 0;
      end
    end else begin
      l  = int'(m_lfsr);
      cx = (l % (1 << CW)) / STEP * STEP;
      cy = ((((l << 8) | (l >> 8)) & 'hFFFF) % (1 << CW)) / STEP * STEP;
      ok = (cx >= XMIN) && (cx <= XMAX) && (cy >= YMIN) && (cy <= YMAX) &&
           !(cx == int'(snake_x) && cy == int'(snake_y));
      for (int i = 0; i < N; i++)
        if (m_alive[i] && m_x[i] == cx && m_y[i] == cy) ok = 0;
      hits = '0;
      if (m_phase == M_ACTIVE || m_phase == M_RESPAWN)
        for (int i = 0; i < N; i++)
          if (m_alive[i] && m_x[i] == int'(snake_x) && m_y[i] == int'(snake_y)) hits[i] = 1'b1;
      due = -1;
      hidx = 0;
      for (int i = N - 1; i >= 0; i--) begin
        if (!m_alive[i] && m_tmr[i] == 0) due = i;
        if (hits[i]) hidx = i;
      end
      m_hv = (hits != '0); m_hmask = hits; m_hidx = hidx;
      if (m_phase != M_IDLE)
        for (int i = 0; i < N; i++) if (m_tmr[i] > 0) m_tmr[i]--;
      for (int i = 0; i < N; i++)
        if (hits[i]) begin
          m_alive[i] = 0; m_x[i] = PARK; m_y[i] = PARK; m_tmr[i] = RESP;
        end
      case (m_phase)
        M_IDLE:   if (start) begin m_phase = M_SPAWN; m_slot = 0; end
        M_SPAWN:  if (ok) begin
                    m_x[m_slot] = cx; m_y[m_slot] = cy; m_alive[m_slot] = 1;
                    if (m_slot == N - 1) m_phase = M_ACTIVE; else m_slot++;
                  end
        M_ACTIVE: if (due >= 0) begin m_phase = M_RESPAWN; m_slot = due; end
        default:  if (ok) begin
                    m_x[m_slot] = cx; m_y[m_slot] = cy; m_alive[m_slot] = 1;
                    m_phase = M_ACTIVE;
                  end
      endcase
      m_lfsr = lfsr_next(m_lfsr);
    end
  end

  // Every-cycle scoreboard against the model, away from the active edge.
  always @(negedge clk) begin : scoreboard
    logic [N*CW-1:0] wx, wy;
    logic [N-1:0]    wa;
    for (int i = 0; i < N; i++) begin
      wx[i*CW +: CW] = CW'(m_x[i]);
      wy[i*CW +: CW] = CW'(m_y[i]);
      wa[i]          = m_alive[i];
    end
    check_val("x_flat", spider_x_flat, wx);
    check_val("y_flat", spider_y_flat, wy);
    check_val("alive", spider_alive, wa);
    check_val("hit_valid", hit_valid, m_hv);
    check_val("ready", ready, (m_phase == M_ACTIVE));
    if (m_hv) begin
      check_val("hit_idx", hit_idx, m_hidx);
      check_val("hit_mask", hit_mask, m_hmask);
      $display("hit   t=%0t idx=%0d mask=%b snake=(%0d,%0d)", $time, hit_idx, hit_mask, snake_x, snake_y);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_until_ready(input int budget, input string tag);
    int k = 0;
    while (!ready && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!ready) check_val(tag, ready, 1);
  endtask

  task automatic check_geometry(input string tag);
    int xi, yi, xj, yj;
    for (int i = 0; i < N; i++) begin
      xi = int'(spider_x_flat[i*CW +: CW]);
      yi = int'(spider_y_flat[i*CW +: CW]);
      check_val({tag, "_grid"}, (xi % STEP) + (yi % STEP), 0);
      check_val({tag, "_bounds"}, (xi >= XMIN && xi <= XMAX && yi >= YMIN && yi <= YMAX), 1);
      for (int j = i + 1; j < N; j++) begin
        xj = int'(spider_x_flat[j*CW +: CW]);
        yj = int'(spider_y_flat[j*CW +: CW]);
        check_val({tag, "_unique"}, (xi == xj && yi == yj), 0);
      end
    end
  endtask

  logic [N*CW-1:0] park_flat;
  logic [N*CW-1:0] save_x, save_y;
  int d, pulses, s, r;

  initial begin
    for (int i = 0; i < N; i++) park_flat[i*CW +: CW] = CW'(PARK);

    // Reset held 3 cycles with start asserted: start must be ignored.
    reset = 1; start = 1; snake_x = '0; snake_y = '0;
    repeat (3) @(negedge clk);
    check_val("rst_x", spider_x_flat, park_flat);
    check_val("rst_y", spider_y_flat, park_flat);
    check_val("rst_alive", spider_alive, 0);
    check_val("rst_ready", ready, 0);
    reset = 0; start = 0;
    repeat (3) @(negedge clk);
    check_val("idle_alive", spider_alive, 0);

    // Initial spawn with the snake at the origin.
    start = 1;
    @(negedge clk);
    start = 0;
    wait_until_ready(3000, "spawn_timeout");
    $display("spawn t=%0t alive=%b", $time, spider_alive);
    check_val("spawn_alive", spider_alive, 5'b11111);
    check_geometry("spawn");

    // Directed hit on slot 2, then park the snake at (PARK,PARK).
    save_x = spider_x_flat;
    save_y = spider_y_flat;
    snake_x = spider_x_flat[2*CW +: CW];
    snake_y = spider_y_flat[2*CW +: CW];
    @(negedge clk);
    check_val("hit2_valid", hit_valid, 1);
    check_val("hit2_idx", hit_idx, 2);
    check_val("hit2_mask", hit_mask, 5'b00100);
    check_val("hit2_park_x", spider_x_flat[2*CW +: CW], PARK);
    check_val("hit2_park_y", spider_y_flat[2*CW +: CW], PARK);
    snake_x = CW'(PARK);
    snake_y = CW'(PARK);
    @(negedge clk);
    check_val("hit2_clear", hit_valid, 0);
    d = 1;
    pulses = 0;
    while (!spider_alive[2] && d < 300) begin
      @(negedge clk);
      d++;
      if (hit_valid) pulses++;
    end
    check_val("park_no_hit", pulses, 0);
    check_val("respawn_seen", spider_alive[2], 1);
    check_val("respawn_delay_ge17", (d >= 17), 1);
    for (int i = 0; i < N; i++) begin
      if (i != 2) begin
        check_val("others_x", spider_x_flat[i*CW +: CW], save_x[i*CW +: CW]);
        check_val("others_y", spider_y_flat[i*CW +: CW], save_y[i*CW +: CW]);
      end
    end
    @(negedge clk);
    check_geometry("respawn");

    // Randomized play: snake jumps onto spiders, parked coords, grid and noise.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      r = $urandom_range(0, 7);
      if (r < 3) begin
        s = $urandom_range(0, N - 1);
        snake_x = CW'(m_x[s]);
        snake_y = CW'(m_y[s]);
      end else if (r < 5) begin
        snake_x = CW'($urandom_range(XMIN / STEP, XMAX / STEP) * STEP);
        snake_y = CW'($urandom_range(YMIN / STEP, YMAX / STEP) * STEP);
      end else begin
        snake_x = CW'($urandom);
        snake_y = CW'($urandom);
      end
      start = ($urandom_range(0, 15) == 0);
    end
    start = 0;
    snake_x = '0;
    snake_y = '0;

    // Reset in the middle of spawning slot 3, then a fresh full spawn.
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    d = 0;
    while (!(m_phase == M_SPAWN && m_slot == 3) && d < 3000) begin
      @(negedge clk);
      d++;
    end
    check_val("mid_spawn_alive", spider_alive, 5'b00111);
    reset = 1;
    @(negedge clk);
    check_val("mid_rst_x", spider_x_flat, park_flat);
    check_val("mid_rst_y", spider_y_flat, park_flat);
    check_val("mid_rst_alive", spider_alive, 0);
    check_val("mid_rst_ready", ready, 0);
    reset = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    wait_until_ready(3000, "respawn_all_timeout");
    check_val("respawn_all_alive", spider_alive, 5'b11111);
    check_geometry("rerun");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/spider_field.md
Name: spider_field

Overview:
- Parametrised hazard field: holds NUM_SPIDERS spider positions, spawns them pseudo-randomly on a STEP-aligned grid, and detects snake/spider collisions.
- Reports each hit to game control, parks the hit spider, and respawns it after a delay.
- Sits beside the snake datapath; positions feed the renderer, hit outputs feed the game-over/score FSM.

Parameters:
- NUM_SPIDERS, 5, number of spider slots (1..16)
- COORD_W, 12, coordinate width in bits
- STEP, 32, grid pitch; power of two; spawned coords are multiples of STEP
- X_MIN, 64 / X_MAX, 896, inclusive spawn bounds, x
- Y_MIN, 64 / Y_MAX, 832, inclusive spawn bounds, y
- PARK, 700, coordinate given to dead or unspawned spiders
- RESPAWN_CYCLES, 1024, cycles between a hit and respawn eligibility
- SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins initial spawn from IDLE
- snake_x  in  COORD_W  snake head x
- snake_y  in  COORD_W  snake head y
- spider_x_flat  out  NUM_SPIDERS*COORD_W  slot i at bits [i*COORD_W +: COORD_W]
- spider_y_flat  out  NUM_SPIDERS*COORD_W  same packing as x
- spider_alive  out  NUM_SPIDERS  per-slot alive mask
- hit_valid  out  1  one-cycle hit pulse
- hit_idx  out  $clog2(NUM_SPIDERS)  lowest hit slot index, valid with hit_valid
- hit_mask  out  NUM_SPIDERS  all slots hit this event
- ready  out  1  high in ACTIVE

Behaviour:
- Reset: all x/y = PARK; spider_alive, hit_valid, hit_mask, hit_idx = 0; ready = 0; all timers = 0; LFSR = SEED; FSM = IDLE.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every cycle except in reset.
- Candidates:
  - cand_x = lfsr[COORD_W-1:0] with low log2(STEP) bits cleared.
  - cand_y = rotate-left-by-8 of lfsr, truncated to COORD_W bits, low log2(STEP) bits cleared.
  - A candidate is valid only if within [MIN, MAX] on both axes, unequal to the snake position, and unequal to every alive spider position.
- FSM states:
  - IDLE: all spiders parked. On start -> SPAWN with slot = 0. Without start, stay in IDLE.
  - SPAWN: one attempt per cycle. If the candidate is valid, write it to the slot, set alive, and slot++. If invalid, retry next cycle on the new LFSR value. After slot NUM_SPIDERS-1 is written -> ACTIVE.
  - ACTIVE: ready = 1. Each cycle, compare the snake with every alive slot.
    - On any match, the next edge registers: hit_valid = 1, hit_mask = matched slots, hit_idx = lowest matched slot.
    - On that same edge, matched slots get alive = 0, x/y = PARK, timer = RESPAWN_CYCLES.
    - Detection latency is exactly 1 cycle. hit_valid self-clears the cycle after.
  - RESPAWN: entered from ACTIVE when some dead slot's timer is 0; the lowest such slot is chosen. Uses the same validity rule as SPAWN, one attempt per cycle. On success -> ACTIVE. Collision detection continues in RESPAWN; ready = 0.
- Timers decrement every cycle while nonzero, in every state except IDLE.
- Parked or dead slots never generate hits, even if the snake is at PARK.
- start outside IDLE is ignored.
- Reset in any state: returns to full reset values on the next edge; any in-flight hit pulse is lost.
- Simultaneous hit and respawn completion on the same slot cannot occur: a respawning slot is dead until written.

Optional Feature:
- Macro: SPIDER_DRIFT_EN.
- Defined: every 2^20 cycles (free-running counter), each alive spider moves ±STEP in x or y, direction chosen from LFSR bits [2i+1:2i]. A move that would leave the bounds or land on the snake is skipped. A hit on the same cycle takes priority over the move.
- Undefined: alive spiders are static; the counter and the move logic are absent.

Decomposition:
- Package spider_pkg: LFSR width and taps constant, FSM state enum (IDLE, SPAWN, ACTIVE, RESPAWN), default PARK and bounds constants.
- One sub-module: spider_lfsr (clk, reset, seed, lfsr out); shared with the future food spawner.

Test Plan:
- Reset held 3 cycles -> all x/y = 700, alive = 0, ready = 0; start ignored while reset is high.
- start with snake at (0,0) -> ready rises once 5 slots are written; every coord is a multiple of 32, x in [64,896], y in [64,832]; no duplicate positions.
- Snake driven to slot 2's position for 1 cycle -> hit_valid = 1 on the next cycle with hit_idx = 2, hit_mask = 5'b00100; slot 2 parked at (700,700); hit_valid = 0 the cycle after.
- Snake held at (700,700) after a hit -> no further hit_valid.
- Same hit, RESPAWN_CYCLES = 16 -> slot 2 alive again 17..N cycles later at a new valid position; the other slots never change.
- Reset asserted mid-SPAWN at slot 3 -> returns to IDLE with all slots parked; a new start respawns all 5.
